// File: rtl/iter_shift_seq.sv
// Iterative barrel-shift sequencer: applies 16/8/4/2/1 stages one per clock (SLL or SRA).
// Optional build macro ITER_SHIFT_EARLY_EXIT_EN finishes as soon as no lower stage bits remain.
module iter_shift_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [DATA_WIDTH-1:0]  data_operandA,
   input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
   input  logic                   ctrl_shiftop,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  data_result,
   output logic                   out_valid,
   input  logic                   out_ready
);

   // state  | meaning
   // IDLE   | waiting for a request, in_ready=1
   // SHIFT  | applying stage k (2**k) to the working register, k counts down
   // DONE   | result presented, waiting for out_ready
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int K_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
   localparam logic [K_W-1:0] K_TOP = K_W'(SHAMT_WIDTH - 1);

   state_t                 state_q, state_d;
   logic [K_W-1:0]         k_q, k_d;
   logic [DATA_WIDTH-1:0]  work_q, work_d;
   logic [SHAMT_WIDTH-1:0] amt_q, amt_d;
   logic                   op_q, op_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic                   out_valid_q, out_valid_d;

   logic [SHAMT_WIDTH-1:0] stage_dist;
   logic [DATA_WIDTH-1:0]  work_sll;
   logic [DATA_WIDTH-1:0]  work_sra;
   logic [DATA_WIDTH-1:0]  work_stage;
   logic                   last_stage;
`ifdef ITER_SHIFT_EARLY_EXIT_EN
   logic                   lower_zero;
`endif

   // Stage distance 2**k; the arithmetic shift replicates the MSB, which never changes across stages.
   always_comb begin
      stage_dist = SHAMT_WIDTH'(1) << k_q;
      work_sll   = work_q << stage_dist;
      work_sra   = $unsigned($signed(work_q) >>> stage_dist);
      work_stage = work_q;
      if (amt_q[k_q]) begin
         work_stage = op_q ? work_sra : work_sll;
      end
`ifdef ITER_SHIFT_EARLY_EXIT_EN
      lower_zero = ((amt_q & (stage_dist - SHAMT_WIDTH'(1))) == '0);
      last_stage = (k_q == '0) || lower_zero;
`else
      last_stage = (k_q == '0);
`endif
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      work_d      = work_q;
      amt_d       = amt_q;
      op_d        = op_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d  = data_operandA;
               amt_d   = ctrl_shiftamt;
               op_d    = ctrl_shiftop;
               k_d     = K_TOP;
               state_d = ST_SHIFT;
`ifdef ITER_SHIFT_EARLY_EXIT_EN
               if (ctrl_shiftamt == '0) begin
                  state_d     = ST_DONE;
                  result_d    = data_operandA;
                  out_valid_d = 1'b1;
               end
`endif
            end
         end

         ST_SHIFT: begin
            work_d = work_stage;
            if (last_stage) begin
               state_d     = ST_DONE;
               result_d    = work_stage;
               out_valid_d = 1'b1;
            end else begin
               k_d = k_q - K_W'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         k_q         <= K_TOP;
         work_q      <= '0;
         amt_q       <= '0;
         op_q        <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         work_q      <= work_d;
         amt_q       <= amt_d;
         op_q        <= op_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign data_result = result_q;
   assign out_valid   = out_valid_q;

endmodule
